// File: rtl/mole_round_if.sv
// rtl/mole_round_if.sv - signal bundle between the round controller and the random source, button decoder and display
interface mole_round_if #(
    parameter int SCORE_W = 4,
    parameter int RND_W   = 4
) ();
  logic               start;
  logic [2:0]         mole_pos;
  logic               eval_now;
  logic [2:0]         user_guess;
  logic               guess_now;
  logic [2:0]         mole_out;
  logic [SCORE_W-1:0] score;
  logic [RND_W-1:0]   round_cnt;
  logic               hit;
  logic               miss;
  logic               game_over;

  modport master (
    output start, mole_pos, eval_now, user_guess,
    input  guess_now, mole_out, score, round_cnt, hit, miss, game_over
  );

  modport slave (
    input  start, mole_pos, eval_now, user_guess,
    output guess_now, mole_out, score, round_cnt, hit, miss, game_over
  );
endinterface

// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - whack-a-mole round sequencer: shows a mole, opens the guess window, judges hit/miss
module mole_round_ctrl #(
    parameter int ROUND_TICKS = 50_000_000,
    parameter int GAP_TICKS   = 10_000_000,
    parameter int NUM_ROUNDS  = 10,
    parameter int SCORE_W     = 4,
    parameter int RND_W       = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mole_round_if.slave  bus
);

  localparam int TICK_MAX = (ROUND_TICKS > GAP_TICKS) ? ROUND_TICKS : GAP_TICKS;
  localparam int TIMER_W  = $clog2(TICK_MAX);

  localparam logic [TIMER_W-1:0] ROUND_LAST  = TIMER_W'(ROUND_TICKS - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST    = TIMER_W'(GAP_TICKS - 1);
  localparam logic [RND_W-1:0]   ROUND_LIMIT = RND_W'(NUM_ROUNDS);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [2:0]         NO_HOLE     = 3'd5;

  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               guess_now_q;
  logic [2:0]         mole_q;
  logic [SCORE_W-1:0] score_q;
  logic [RND_W-1:0]   round_q;
  logic               hit_q;
  logic               miss_q;
  logic               game_over_q;

  logic               guess_valid;
  logic               judge;
  logic               is_hit;
  logic [2:0]         mole_fold;
  logic [SCORE_W-1:0] score_inc;

  // Guesses of 5..7 mean "no button" and never count as an answer.
  assign guess_valid = bus.eval_now && (bus.user_guess <= 3'd4);
  assign judge       = guess_valid || (timer == ROUND_LAST);
  assign is_hit      = guess_valid && (bus.user_guess == mole_q);

  // The random source spans 0..7; fold 5..7 back onto 0..2 so a hole is always lit.
  assign mole_fold   = (bus.mole_pos <= 3'd4) ? bus.mole_pos : bus.mole_pos - 3'd5;
  assign score_inc   = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      guess_now_q <= 1'b0;
      mole_q      <= NO_HOLE;
      score_q     <= '0;
      round_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state       <= SHOW;
            timer       <= '0;
            guess_now_q <= 1'b1;
            mole_q      <= mole_fold;
            score_q     <= '0;
            round_q     <= '0;
            game_over_q <= 1'b0;
          end
        end

        SHOW: begin
          // A valid guess in the timeout cycle wins over the timeout.
          if (judge) begin
            state       <= GAP;
            timer       <= '0;
            guess_now_q <= 1'b0;
            mole_q      <= NO_HOLE;
            round_q     <= round_q + RND_W'(1);
            hit_q       <= is_hit;
            miss_q      <= !is_hit;
            if (is_hit) begin
              score_q <= score_inc;
            end
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            if (round_q == ROUND_LIMIT) begin
              state       <= DONE;
              game_over_q <= 1'b1;
            end else begin
              state       <= SHOW;
              guess_now_q <= 1'b1;
              mole_q      <= mole_fold;
            end
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.guess_now = guess_now_q;
  assign bus.mole_out  = mole_q;
  assign bus.score     = score_q;
  assign bus.round_cnt = round_q;
  assign bus.hit       = hit_q;
  assign bus.miss      = miss_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb/tb_mole_round_ctrl.sv - table-driven, scoreboarded bench for mole_round_ctrl
module tb_mole_round_ctrl;

  localparam int RT = 8;
  localparam int GT = 4;
  localparam int NR = 3;
  localparam int SW = 4;
  localparam int RW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mole_round_if #(.SCORE_W(SW), .RND_W(RW)) bus ();

  mole_round_ctrl #(
    .ROUND_TICKS(RT),
    .GAP_TICKS  (GT),
    .NUM_ROUNDS (NR),
    .SCORE_W    (SW),
    .RND_W      (RW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0] mole_pos;
    int         eval_at;     // SHOW cycle of the answering eval, -1 = let it time out
    logic [2:0] guess;
    int         bad_at;      // SHOW cycle of an eval with an out-of-range guess, -1 = none
    logic [2:0] bad_guess;
    bit         noise;       // start held high and mole_pos churned during the round
    logic [2:0] exp_mole;
    bit         exp_hit;
    int         exp_score;
    int         exp_rnd;
  } round_t;

  typedef struct {
    bit hit;
    int score;
    int rnd;
  } judge_t;

  round_t tbl[7];
  judge_t sb[$];
  int     n_vec = 0;
  int     n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.hit || bus.miss)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, bus.hit, bus.miss}, 32'd0);
      end else begin
        judge_t j;
        j = sb.pop_front();
        chk("hit", bus.hit, j.hit);
        chk("miss", bus.miss, !j.hit);
        chk("score", bus.score, j.score);
        chk("round_cnt", bus.round_cnt, j.rnd);
      end
    end
  end

  task automatic play_round(input round_t r, input round_t nxt);
    bit judged;
    judge_t j;
    chk("show_guess_now", bus.guess_now, 1);
    chk("show_mole_out", bus.mole_out, r.exp_mole);
    bus.start = r.noise;
    for (int t = 0; t < RT; t++) begin
      bus.eval_now   = 1'b0;
      bus.user_guess = 3'd5;
      if (r.noise) bus.mole_pos = 3'($urandom_range(0, 7));
      if (t == r.bad_at) begin
        bus.eval_now   = 1'b1;
        bus.user_guess = r.bad_guess;
      end
      if (t == r.eval_at) begin
        bus.eval_now   = 1'b1;
        bus.user_guess = r.guess;
      end
      judged = (t == r.eval_at) || (r.eval_at < 0 && t == RT - 1);
      if (judged) begin
        j.hit   = r.exp_hit;
        j.score = r.exp_score;
        j.rnd   = r.exp_rnd;
        sb.push_back(j);
      end
      tick();
      if (judged) break;
      chk("show_hold_guess_now", bus.guess_now, 1);
      chk("show_hold_mole_out", bus.mole_out, r.exp_mole);
    end
    // Evals during the gap must be ignored, even one matching the old mole.
    bus.mole_pos   = nxt.mole_pos;
    bus.eval_now   = 1'b1;
    bus.user_guess = r.exp_mole;
    @(negedge clk);
    #1;
    chk("judge_latency", sb.size(), 0);
    for (int g = 0; g < GT; g++) begin
      chk("gap_guess_now", bus.guess_now, 0);
      chk("gap_mole_out", bus.mole_out, 5);
      tick();
    end
    bus.eval_now = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic play_game(input int base);
    bus.mole_pos = tbl[base].mole_pos;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_score_clr", bus.score, 0);
    chk("start_round_clr", bus.round_cnt, 0);
    chk("start_game_over", bus.game_over, 0);
    for (int i = 0; i < NR; i++) begin
      play_round(tbl[base + i], tbl[(i < NR - 1) ? base + i + 1 : base + i]);
    end
    for (int k = 0; k < 3; k++) begin
      chk("done_game_over", bus.game_over, 1);
      chk("done_round_cnt", bus.round_cnt, NR);
      chk("done_score", bus.score, tbl[base + NR - 1].exp_score);
      chk("done_guess_now", bus.guess_now, 0);
      chk("done_mole_out", bus.mole_out, 5);
      tick();
    end
  endtask

  initial begin
    tbl[0] = '{3'd3, 2, 3'd3, -1, 3'd5, 1'b0, 3'd3, 1'b1, 1, 1};
    tbl[1] = '{3'd6, 0, 3'd1, -1, 3'd5, 1'b0, 3'd1, 1'b1, 2, 2};
    tbl[2] = '{3'd2, 5, 3'd4,  1, 3'd7, 1'b0, 3'd2, 1'b0, 2, 3};
    tbl[3] = '{3'd7, -1, 3'd0, 3, 3'd5, 1'b0, 3'd2, 1'b0, 0, 1};
    tbl[4] = '{3'd4, 7, 3'd4, -1, 3'd5, 1'b1, 3'd4, 1'b1, 1, 2};
    tbl[5] = '{3'd5, 1, 3'd0,  0, 3'd6, 1'b1, 3'd0, 1'b1, 2, 3};
    tbl[6] = '{3'd1, 0, 3'd1, -1, 3'd5, 1'b0, 3'd1, 1'b1, 1, 1};

    bus.start      = 1'b0;
    bus.mole_pos   = 3'd0;
    bus.eval_now   = 1'b0;
    bus.user_guess = 3'd5;

    tick();
    tick();
    chk("rst_guess_now", bus.guess_now, 0);
    chk("rst_mole_out", bus.mole_out, 5);
    chk("rst_score", bus.score, 0);
    chk("rst_round_cnt", bus.round_cnt, 0);
    chk("rst_hit_miss", {bus.hit, bus.miss}, 0);
    chk("rst_game_over", bus.game_over, 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_guess_now", bus.guess_now, 0);

    play_game(0);
    play_game(3);

    // Reset in the middle of a round, with a non-zero score to clear.
    bus.mole_pos = tbl[6].mole_pos;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    play_round(tbl[6], tbl[6]);
    tick();
    tick();
    chk("pre_reset_score", bus.score, 1);
    chk("pre_reset_guess_now", bus.guess_now, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_guess_now", bus.guess_now, 0);
    chk("async_rst_mole_out", bus.mole_out, 5);
    chk("async_rst_score", bus.score, 0);
    chk("async_rst_round_cnt", bus.round_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_idle_guess_now", bus.guess_now, 0);
    chk("post_rst_idle_mole_out", bus.mole_out, 5);
    bus.mole_pos = 3'd4;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart_guess_now", bus.guess_now, 1);
    chk("restart_mole_out", bus.mole_out, 4);
    chk("restart_score", bus.score, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
